serial_transmitter: RTL and testbench
=====================================

Name: serial_transmitter

Overview:
- Parallel-to-serial transmit stage (Tx) sitting directly upstream of the team's receiver (Rx); SDout connects straight to the receiver's serial data input, and both run on the same serial clock.
- Accepts bytes through a valid/ready handshake into a one-entry holding register. This lets the producer queue the next byte while the current frame shifts out.
- Serialises each byte as a one-cycle start bit, eight data bits LSB first, then STOP_BITS low cycles.
- Idle line level is low.

Parameters:
- STOP_BITS, 1, number of low cycles after bit 7 before the next start bit can appear. Legal range 1..15. Values below 1 are illegal because the receiver needs at least one gap cycle.
- DATA_W, 8, data width. Fixed at 8 when paired with the receiver; other values are unsupported.

Ports:
- SCin  input  1  serial clock; all state updates on its rising edge.
- RSTn  input  1  reset, synchronous, active-low.
- PDin  input  8  parallel data from the producer.
- PDvalid  input  1  PDin is valid this cycle.
- PDaccept  output  1  holding register empty; a byte transfers on any rising edge where PDvalid and PDaccept are both 1.
- SDout  output  1  serial data to the receiver, registered.
- Busy  output  1  high while a frame (start, data or stop) is on SDout, or while the holding register is full.
- TxDone  output  1  one-cycle pulse during the final stop cycle of each frame.

Behaviour:
- Reset (RSTn=0 at a rising edge) forces the following, regardless of frame progress:
  - SDout=0, PDaccept=1, Busy=0, TxDone=0.
  - FSM goes to IDLE; holding register and shift register are cleared; bit and stop counters are cleared.
  - A partially sent frame is abandoned and the line goes low.
- Handshake:
  - PDaccept = NOT hold_full, registered.
  - On a transfer edge, hold <= PDin and hold_full <= 1.
  - hold_full clears on the edge that moves hold into the shift register; PDaccept is therefore low for at least one cycle after each accept.
  - A byte presented while PDaccept=0 is neither lost nor duplicated; the producer keeps PDvalid and PDin stable until it is accepted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: SDout=0. At an edge with hold_full=1: shift register <= hold, hold_full <= 0, SDout <= 1, go to START.
  - START: lasts one cycle (SDout=1). At the next edge: SDout <= shift[0], shift right, bitcnt <= 1, go to DATA.
  - DATA: SDout carries bit (bitcnt-1).
    - Each edge with bitcnt<8: SDout <= shift[0], shift right, bitcnt <= bitcnt+1.
    - Edge with bitcnt=8: SDout <= 0, stopcnt <= 1, go to STOP.
  - STOP: SDout=0.
    - If stopcnt<STOP_BITS: stopcnt <= stopcnt+1.
    - If stopcnt=STOP_BITS (final stop cycle): TxDone=1 that cycle. At the edge: if hold_full, behave exactly as IDLE-with-hold (load, SDout <= 1, go to START); otherwise go to IDLE.
- Latency: accept at edge E while IDLE. Start bit on SDout from E+1 to E+2; data bit k from E+2+k; first stop cycle from E+10.
- Throughput: back-to-back frame period = 9 + STOP_BITS cycles, with no extra idle cycle when hold is pre-filled.
- Receiver compatibility: every frame contains exactly one high start cycle, followed by at least one low gap cycle after bit 7. This meets the receiver's start-detect and counter-recovery timing.
- Busy = (state != IDLE) OR hold_full.

Test Plan:
- Reset then single byte 0xA5 (STOP_BITS=1): SDout sequence from E+1 is 1,1,0,1,0,0,1,0,1,0; TxDone high in the last cycle; then IDLE with SDout=0 and Busy=0.
- Back-to-back 0x00 then 0xFF, with the second byte accepted while the first is in DATA: start bits exactly 10 cycles apart; second frame is 1,1,1,1,1,1,1,1,1,0; PDaccept low from the accept until the second start edge.
- Hold PDvalid=1 with 0x3C while PDaccept=0: exactly one frame for 0x3C; no duplicate after PDvalid drops.
- Loopback into the receiver on a shared SCin, sending 0x01, 0x80, 0x5A: the receiver reports the same byte at each PDready pulse and never sees a false start.
- RSTn low during DATA bit 4: SDout=0 and PDaccept=1 from the next edge; a new byte 0xC3 afterwards transmits cleanly.
- STOP_BITS=3, two queued bytes: exactly 3 low cycles between bit 7 and the next start bit; frame period 12 cycles.

Source files
------------

// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Parallel-to-serial transmit stage feeding the team's serial receiver.
//   Bytes enter through a valid/ready handshake into a one-entry holding
//   register. Each byte goes out as one high start cycle, DATA_W data bits
//   LSB first, then STOP_BITS low cycles. The idle line level is low.
//
// Ports
//   SCin      in   serial clock; all state changes on its rising edge
//   RSTn      in   synchronous active-low reset
//   PDin      in   parallel data from the producer
//   PDvalid   in   PDin valid this cycle
//   PDaccept  out  holding register empty (registered); transfer = PDvalid & PDaccept
//   SDout     out  registered serial data to the receiver
//   Busy      out  frame on the line or holding register full
//   TxDone    out  one-cycle pulse during the final stop cycle of each frame
module serial_transmitter #(
  parameter int unsigned STOP_BITS = 1,   // legal range 1..15
  parameter int unsigned DATA_W    = 8    // must be 8 when paired with the receiver
) (
  input  logic              SCin,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] PDin,
  input  logic              PDvalid,
  output logic              PDaccept,
  output logic              SDout,
  output logic              Busy,
  output logic              TxDone
);

  localparam int unsigned CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LASTBIT = CW'(DATA_W);
  localparam logic [3:0]    LASTSTOP = 4'(STOP_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     bitcnt;
  logic [3:0]        stopcnt;

  logic take;       // producer byte transfers into hold at this edge
  logic last_stop;  // current cycle is the final stop cycle
  logic load;       // hold moves into the shift register at this edge
  logic hold_full_nxt;

  always_comb begin
    take          = PDvalid & PDaccept;
    last_stop     = (state == STOP) && (stopcnt == LASTSTOP);
    load          = hold_full & ((state == IDLE) | last_stop);
    // take and load never coincide: PDaccept is low whenever hold is full
    hold_full_nxt = hold_full;
    if (take)
      hold_full_nxt = 1'b1;
    else if (load)
      hold_full_nxt = 1'b0;
  end

  always_ff @(posedge SCin) begin
    if (!RSTn) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      bitcnt    <= '0;
      stopcnt   <= '0;
      SDout     <= 1'b0;
      PDaccept  <= 1'b1;
      TxDone    <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      PDaccept  <= ~hold_full_nxt;
      TxDone    <= 1'b0;
      if (take)
        hold <= PDin;

      case (state)
        IDLE: begin
          SDout <= 1'b0;
          if (load) begin
            shift <= hold;
            SDout <= 1'b1;
            state <= START;
          end
        end
        START: begin
          SDout  <= shift[0];
          shift  <= shift >> 1;
          bitcnt <= CW'(1);
          state  <= DATA;
        end
        DATA: begin
          if (bitcnt < LASTBIT) begin
            SDout  <= shift[0];
            shift  <= shift >> 1;
            bitcnt <= bitcnt + CW'(1);
          end else begin
            SDout   <= 1'b0;
            stopcnt <= 4'd1;
            state   <= STOP;
            // TxDone is registered, so it is raised on entry to the final stop cycle
            TxDone  <= (LASTSTOP == 4'd1);
          end
        end
        STOP: begin
          SDout <= 1'b0;
          if (!last_stop) begin
            stopcnt <= stopcnt + 4'd1;
            TxDone  <= ((stopcnt + 4'd1) == LASTSTOP);
          end else if (load) begin
            // queued byte starts with no idle cycle between frames
            shift <= hold;
            SDout <= 1'b1;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          SDout <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_serial_transmitter.sv
module tb_serial_transmitter;

  logic       clk;
  logic       rstn;
  logic [7:0] pdin;
  logic       pdvalid;
  logic       pdaccept;
  logic       sdout;
  logic       busy;
  logic       txdone;

  logic [7:0] pdin3;
  logic       pdvalid3;
  logic       pdaccept3;
  logic       sdout3;
  logic       busy3;
  logic       txdone3;

  int vectors    = 0;
  int miscompares = 0;

  serial_transmitter #(.STOP_BITS(1), .DATA_W(8)) dut (
    .SCin(clk), .RSTn(rstn), .PDin(pdin), .PDvalid(pdvalid),
    .PDaccept(pdaccept), .SDout(sdout), .Busy(busy), .TxDone(txdone)
  );

  serial_transmitter #(.STOP_BITS(3), .DATA_W(8)) dut3 (
    .SCin(clk), .RSTn(rstn), .PDin(pdin3), .PDvalid(pdvalid3),
    .PDaccept(pdaccept3), .SDout(sdout3), .Busy(busy3), .TxDone(txdone3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level j cycles after the accept edge for a frame whose
  // start bit occupies cycle s.
  function automatic logic exp_line(input int j, input int s, input logic [7:0] b);
    if (j == s) return 1'b1;
    if (j > s && j <= s + 8) return b[j-s-1];
    return 1'b0;
  endfunction

  // Producer model: byte queue driven onto pdin/pdvalid, popped on transfer.
  logic [7:0] txq[$];
  logic       prev_acc;
  int         nxfer;

  task automatic producer_step();
    if (pdvalid && prev_acc) begin
      void'(txq.pop_front());
      nxfer++;
    end
    prev_acc = pdaccept;
    if (txq.size() > 0) begin
      pdvalid = 1'b1;
      pdin    = txq[0];
    end else begin
      pdvalid = 1'b0;
    end
  endtask

  // Receiver model: start detect, 8 bits LSB first, mandatory low gap cycle.
  logic       rx_en = 1'b0;
  int         rx_cnt = 0;
  int         rx_false = 0;
  logic [7:0] rx_sh;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (rx_en) begin
      if (rx_cnt == 0) begin
        if (sdout) rx_cnt = 1;
      end else if (rx_cnt <= 8) begin
        rx_sh[rx_cnt-1] = sdout;
        if (rx_cnt == 8) begin
          rxq.push_back(rx_sh);
          rx_cnt = 9;
        end else begin
          rx_cnt++;
        end
      end else begin
        if (sdout) rx_false++;
        rx_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0; pdvalid = 1'b0; pdin = '0; pdvalid3 = 1'b0; pdin3 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sdout, pdaccept, busy, txdone} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset: sdout/pdaccept/busy/txdone got %b want 0100", {sdout, pdaccept, busy, txdone});
    end
    vectors++;
    if ({sdout3, pdaccept3, busy3, txdone3} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset3: sdout/pdaccept/busy/txdone got %b want 0100", {sdout3, pdaccept3, busy3, txdone3});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    pdin = 8'hA5; pdvalid = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) pdvalid = 1'b0;
      vectors++;
      if (sdout !== exp_line(j, 1, 8'hA5)) begin
        miscompares++;
        $display("FAIL single_sdout j=%0d got %b want %b", j, sdout, exp_line(j, 1, 8'hA5));
      end
      vectors++;
      if (txdone !== (j == 10)) begin
        miscompares++;
        $display("FAIL single_txdone j=%0d got %b want %b", j, txdone, (j == 10));
      end
      vectors++;
      if (busy !== (j <= 10)) begin
        miscompares++;
        $display("FAIL single_busy j=%0d got %b want %b", j, busy, (j <= 10));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic le, ae;
    pdin = 8'h00; pdvalid = 1'b1;
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      le = exp_line(j, 1, 8'h00) | exp_line(j, 11, 8'hFF);
      ae = (j == 1) || (j == 2) || (j >= 11);
      vectors++;
      if (sdout !== le) begin
        miscompares++;
        $display("FAIL b2b_sdout j=%0d got %b want %b", j, sdout, le);
      end
      vectors++;
      if (pdaccept !== ae) begin
        miscompares++;
        $display("FAIL b2b_pdaccept j=%0d got %b want %b", j, pdaccept, ae);
      end
      vectors++;
      if (txdone !== (j == 10 || j == 20)) begin
        miscompares++;
        $display("FAIL b2b_txdone j=%0d got %b want %b", j, txdone, (j == 10 || j == 20));
      end
      if (j == 0) pdvalid = 1'b0;
      if (j == 2) begin pdin = 8'hFF; pdvalid = 1'b1; end
      if (j == 3) pdvalid = 1'b0;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_hold_stable();
    logic le;
    txq = {8'h11, 8'h22, 8'h3C};
    nxfer = 0;
    producer_step();
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      le = exp_line(j, 1, 8'h11) | exp_line(j, 11, 8'h22) | exp_line(j, 21, 8'h3C);
      vectors++;
      if (sdout !== le) begin
        miscompares++;
        $display("FAIL hold_sdout j=%0d got %b want %b", j, sdout, le);
      end
      producer_step();
    end
    vectors++;
    if (nxfer !== 3) begin
      miscompares++;
      $display("FAIL hold_xfers got %0d want 3", nxfer);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'h5A;
    rxq = {}; rx_cnt = 0; rx_false = 0; rx_en = 1'b1;
    txq = {8'h01, 8'h80, 8'h5A};
    producer_step();
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      producer_step();
    end
    rx_en = 1'b0;
    vectors++;
    if (rxq.size() !== 3) begin
      miscompares++;
      $display("FAIL loop_count got %0d want 3", rxq.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= rxq.size() || rxq[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL loop_byte%0d got %h want %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp_b[i]);
      end
    end
    vectors++;
    if (rx_false !== 0) begin
      miscompares++;
      $display("FAIL loop_gap got %0d high gap cycles want 0", rx_false);
    end
  endtask

  task automatic test_reset_mid();
    txq = {8'hFF};
    nxfer = 0;
    producer_step();
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      vectors++;
      if (sdout !== exp_line(j, 1, 8'hFF)) begin
        miscompares++;
        $display("FAIL rstmid_sdout j=%0d got %b want %b", j, sdout, exp_line(j, 1, 8'hFF));
      end
      producer_step();
    end
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sdout, pdaccept, busy, txdone} !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstmid_state got %b want 0100", {sdout, pdaccept, busy, txdone});
    end
    rstn = 1'b1;
    txq = {8'hC3};
    producer_step();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      vectors++;
      if (sdout !== exp_line(j, 1, 8'hC3)) begin
        miscompares++;
        $display("FAIL rstmid_c3 j=%0d got %b want %b", j, sdout, exp_line(j, 1, 8'hC3));
      end
      producer_step();
    end
  endtask

  task automatic test_stop3();
    logic le, ae;
    pdin3 = 8'h96; pdvalid3 = 1'b1;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      le = exp_line(j, 1, 8'h96) | exp_line(j, 13, 8'h69);
      ae = (j == 1) || (j >= 13);
      vectors++;
      if (sdout3 !== le) begin
        miscompares++;
        $display("FAIL stop3_sdout j=%0d got %b want %b", j, sdout3, le);
      end
      vectors++;
      if (pdaccept3 !== ae) begin
        miscompares++;
        $display("FAIL stop3_pdaccept j=%0d got %b want %b", j, pdaccept3, ae);
      end
      vectors++;
      if (txdone3 !== (j == 12 || j == 24)) begin
        miscompares++;
        $display("FAIL stop3_txdone j=%0d got %b want %b", j, txdone3, (j == 12 || j == 24));
      end
      if (j == 0) pdin3 = 8'h69;
      if (j == 2) pdvalid3 = 1'b0;
    end
    vectors++;
    if (busy3 !== 1'b0) begin
      miscompares++;
      $display("FAIL stop3_idle_busy got %b want 0", busy3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stable();
    test_loopback();
    test_reset_mid();
    test_stop3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
